// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the seven-segment scan driver.
//   NUM_DIGITS / NIB_W / DIG_W / SEG_W / AN_W : geometry of the display
//   SEG_OFF / AN_OFF                          : dark drive levels (active-low)
//   frame_t                                   : one display snapshot (digits, dp, blank)
//   hex7()                                    : hex nibble -> a-g segments, active-high
package seg7_scan_driver_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned DIG_W      = $clog2(NUM_DIGITS);
  localparam int unsigned SEG_W      = 8;
  localparam int unsigned AN_W       = NUM_DIGITS;

  localparam logic [SEG_W-1:0] SEG_OFF = 8'hFF;
  localparam logic [AN_W-1:0]  AN_OFF  = 4'b1111;

  // One complete display snapshot; committed as a unit to avoid tearing.
  typedef struct packed {
    logic [NUM_DIGITS*NIB_W-1:0] digits;
    logic [NUM_DIGITS-1:0]       dp;
    logic [NUM_DIGITS-1:0]       blank;
  } frame_t;

  // Reset snapshot: all digits blanked so the display stays dark until first commit.
  localparam frame_t FRAME_RESET = '{digits: '0, dp: '0, blank: '1};

  // Hex glyph table, bit order {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] hex7(input logic [NIB_W-1:0] v);
    logic [6:0] s;
    s = 7'h00;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load/commit handshake between the display data source and the scan driver.
//   load      : 1-cycle request to capture digits_in/dp_in/blank_in
//   digits_in : nibble k at [4k+3:4k], digit 0 rightmost
//   dp_in     : per-digit decimal point enable
//   blank_in  : per-digit force-dark
//   upd_done  : 1-cycle pulse when new data became the active snapshot
//   pending   : captured data not yet committed
interface seg7_scan_driver_if;
  import seg7_scan_driver_pkg::*;

  logic                        load;
  logic [NUM_DIGITS*NIB_W-1:0] digits_in;
  logic [NUM_DIGITS-1:0]       dp_in;
  logic [NUM_DIGITS-1:0]       blank_in;
  logic                        upd_done;
  logic                        pending;

  modport master (
    output load, digits_in, dp_in, blank_in,
    input  upd_done, pending
  );

  modport slave (
    input  load, digits_in, dp_in, blank_in,
    output upd_done, pending
  );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment decoder.
//   nibble : 4-bit hex value
//   seg_c  : {g,f,e,d,c,b,a}, active-high
module seg7_hex_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [6:0]       seg_c
);

  always_comb begin
    seg_c = hex7(nibble);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Data arrives through a shadow register and is committed to the active
// snapshot only at frame boundaries, so every frame shows one coherent value.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : load/commit handshake (slave side)
//   segments   : active-low {dp,g,f,e,d,c,b,a}, registered
//   anodes     : active-low digit enables, registered, at most one low
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100_000,
  parameter int unsigned GUARD    = 1_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seg7_scan_driver_if.slave    bus,
  output logic [SEG_W-1:0]     segments,
  output logic [AN_W-1:0]      anodes
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] div_cnt,   div_nxt;
  logic [DIG_W-1:0] digit_sel, sel_nxt;
  logic             wrap, fb;

  frame_t           shadow_q, active_q, active_nxt, in_frame;
  logic             pending_q, pending_nxt;
  logic             upd_q, upd_nxt;

  logic [NIB_W-1:0] nib_sel;
  logic [6:0]       dec_c;
  logic [SEG_W-1:0] seg_nxt, seg_q;
  logic [AN_W-1:0]  an_nxt, an_q;

  assign in_frame = '{digits: bus.digits_in, dp: bus.dp_in, blank: bus.blank_in};

  // Slot timing and frame boundary detection.
  assign wrap = (div_cnt == CNT_W'(SCAN_DIV - 1));
  assign fb   = wrap && (digit_sel == DIG_W'(NUM_DIGITS - 1));

  // Next-state: counters, commit path and handshake.
  always_comb begin
    div_nxt     = div_cnt + CNT_W'(1);
    sel_nxt     = digit_sel;
    active_nxt  = active_q;
    pending_nxt = pending_q;
    upd_nxt     = 1'b0;

    if (wrap) begin
      div_nxt = '0;
      sel_nxt = digit_sel + DIG_W'(1);
    end

    if (bus.load) begin
      pending_nxt = 1'b1;
    end

    // A load coinciding with the boundary bypasses the shadow entirely.
    if (fb) begin
      pending_nxt = 1'b0;
      if (bus.load) begin
        active_nxt = in_frame;
        upd_nxt    = 1'b1;
      end else if (pending_q) begin
        active_nxt = shadow_q;
        upd_nxt    = 1'b1;
      end
    end
  end

  // Decode the digit that will be selected next cycle so outputs stay registered.
  assign nib_sel = active_nxt.digits[{sel_nxt, 2'b00} +: NIB_W];

  seg7_hex_decode u_dec (
    .nibble (nib_sel),
    .seg_c  (dec_c)
  );

  // Drive: dark during the anti-ghosting guard window or when the digit is blanked.
  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_OFF;
    if ((div_nxt >= CNT_W'(GUARD)) && !active_nxt.blank[sel_nxt]) begin
      an_nxt  = ~(AN_W'(1) << sel_nxt);
      seg_nxt = {~active_nxt.dp[sel_nxt], ~dec_c};
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      digit_sel <= '0;
      shadow_q  <= FRAME_RESET;
      active_q  <= FRAME_RESET;
      pending_q <= 1'b0;
      upd_q     <= 1'b0;
      seg_q     <= SEG_OFF;
      an_q      <= AN_OFF;
    end else begin
      div_cnt   <= div_nxt;
      digit_sel <= sel_nxt;
      if (bus.load) begin
        shadow_q <= in_frame;
      end
      active_q  <= active_nxt;
      pending_q <= pending_nxt;
      upd_q     <= upd_nxt;
      seg_q     <= seg_nxt;
      an_q      <= an_nxt;
    end
  end

  assign bus.upd_done = upd_q;
  assign bus.pending  = pending_q;
  assign segments     = seg_q;
  assign anodes       = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with SCAN_DIV=8, GUARD=2.
// Stimulus pushes hand-computed lit-slot and commit expectations; a monitor
// pops them whenever a digit lights up or upd_done pulses.
module tb_seg7_scan_driver;

  logic       clk;
  logic       rst_n;
  logic [7:0] segments;
  logic [3:0] anodes;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(.SCAN_DIV(8), .GUARD(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .segments (segments),
    .anodes   (anodes)
  );

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
  } slot_t;

  slot_t slot_q[$];
  int    done_q[$];
  int    checks = 0;
  int    errors = 0;
  int    ph;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench timebase: posedges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ph <= 0;
    else        ph <= ph + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (ph=%0d)", name, act, exp, ph);
    end
  endtask

  task automatic push_slot(input logic [3:0] an, input logic [7:0] seg);
    slot_t s;
    s.an  = an;
    s.seg = seg;
    slot_q.push_back(s);
  endtask

  task automatic wait_ph(input int p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ph != p && n < 1000);
    if (ph != p) begin
      checks++;
      errors++;
      $display("FAIL wait_ph: timeout at ph=%0d waiting for %0d", ph, p);
    end
  endtask

  task automatic do_load(input int p, input logic [15:0] d, input logic [3:0] dp,
                         input logic [3:0] bl);
    wait_ph(p);
    bus.load      = 1'b1;
    bus.digits_in = d;
    bus.dp_in     = dp;
    bus.blank_in  = bl;
    wait_ph(p + 1);
    bus.load      = 1'b0;
  endtask

  // Monitor: compares each lit slot start, hold and end, plus each upd_done pulse.
  bit    prev_lit;
  slot_t cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_lit = 1'b0;
    end else begin
      if (anodes != 4'hF && !prev_lit) begin
        if (slot_q.size() == 0) begin
          chk("unexpected_lit", {24'h0, segments, anodes}, 32'h0000_0FFF);
          cur.an  = anodes;
          cur.seg = segments;
        end else begin
          cur = slot_q.pop_front();
          chk("slot_anodes", 32'(anodes), 32'(cur.an));
          chk("slot_segments", 32'(segments), 32'(cur.seg));
          chk("slot_guard_phase", 32'(ph % 8), 32'd2);
        end
      end else if (anodes != 4'hF && prev_lit) begin
        chk("slot_hold", {20'h0, anodes, segments}, {20'h0, cur.an, cur.seg});
      end else if (anodes == 4'hF && prev_lit) begin
        chk("slot_end_phase", 32'(ph % 8), 32'd0);
      end
      if (anodes == 4'hF) begin
        chk("dark_segments", 32'(segments), 32'hFF);
      end
      if (bus.upd_done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_upd_done", 32'(ph), 32'hFFFF_FFFF);
        end else begin
          chk("upd_done_time", 32'(ph), 32'(done_q.pop_front()));
          chk("upd_done_pending", 32'(bus.pending), 32'd0);
        end
      end
      prev_lit = (anodes != 4'hF);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.load      = 1'b0;
    bus.digits_in = 16'h0;
    bus.dp_in     = 4'h0;
    bus.blank_in  = 4'h0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // 1: reset state, then a dark first frame (any lit slot would hit an empty queue).
    wait_ph(0);
    chk("rst_anodes", 32'(anodes), 32'hF);
    chk("rst_segments", 32'(segments), 32'hFF);
    chk("rst_upd_done", 32'(bus.upd_done), 32'd0);
    chk("rst_pending", 32'(bus.pending), 32'd0);

    // 2: 1234 with dp on digit 0, committed at ph=32; frames 1 and 2.
    done_q.push_back(32);
    repeat (2) begin
      push_slot(4'b1110, 8'h19);
      push_slot(4'b1101, 8'hB0);
      push_slot(4'b1011, 8'hA4);
      push_slot(4'b0111, 8'hF9);
    end
    do_load(5, 16'h1234, 4'b0001, 4'b0000);
    chk("pending_after_load", 32'(bus.pending), 32'd1);

    // 3: two loads in one frame; only BEEF commits, at ph=96.
    done_q.push_back(96);
    push_slot(4'b1110, 8'h8E);
    push_slot(4'b1101, 8'h86);
    push_slot(4'b1011, 8'h86);
    push_slot(4'b0111, 8'h83);
    do_load(66, 16'hAAAA, 4'b0000, 4'b0000);
    do_load(70, 16'hBEEF, 4'b0000, 4'b0000);
    chk("pending_after_two_loads", 32'(bus.pending), 32'd1);

    // 4: load in the exact frame-boundary cycle bypasses the shadow.
    done_q.push_back(128);
    push_slot(4'b1110, 8'hC0);
    push_slot(4'b1101, 8'h8E);
    push_slot(4'b1011, 8'hC0);
    push_slot(4'b0111, 8'hC0);
    do_load(127, 16'h00F0, 4'b0000, 4'b0000);
    chk("pending_after_fb_load", 32'(bus.pending), 32'd0);

    // 5: digit 2 blanked; slot 2 stays dark in frames 5 and 6.
    done_q.push_back(160);
    push_slot(4'b1110, 8'h80);
    push_slot(4'b1101, 8'h78);
    push_slot(4'b0111, 8'h12);
    push_slot(4'b1110, 8'h80);
    push_slot(4'b1101, 8'h78);
    do_load(140, 16'h5678, 4'b1010, 4'b0100);

    // 6: reset mid-slot 2 with data pending; nothing may commit afterwards.
    do_load(200, 16'h9999, 4'b0000, 4'b0000);
    chk("pending_before_reset", 32'(bus.pending), 32'd1);
    wait_ph(211);
    rst_n = 1'b0;
    #1;
    chk("async_rst_anodes", 32'(anodes), 32'hF);
    chk("async_rst_segments", 32'(segments), 32'hFF);
    chk("async_rst_pending", 32'(bus.pending), 32'd0);
    chk("async_rst_upd_done", 32'(bus.upd_done), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_ph(70);
    chk("pending_after_reset", 32'(bus.pending), 32'd0);
    chk("anodes_after_reset", 32'(anodes), 32'hF);

    chk("slot_queue_drained", 32'(slot_q.size()), 32'd0);
    chk("done_queue_drained", 32'(done_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
